bit_serial_add_ctrl: RTL and testbench

BIT_SERIAL_ADD_CTRL -- requirements
Module: bit_serial_add_ctrl

---
 rtl/bit_serial_add_ctrl_pkg.sv | 13 +
 rtl/bit_serial_add_ctrl_if.sv | 27 ++
 rtl/bit_serial_add_ctrl_fa.sv | 21 ++
 rtl/bit_serial_add_ctrl.sv | 107 ++++++++++
 tb/tb_bit_serial_add_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/bit_serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state type
// and the default operand width.
package bit_serial_add_ctrl_pkg;

  localparam int unsigned BSA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bsa_state_e;

endpackage

// File: rtl/bit_serial_add_ctrl_if.sv
// Request/result bundle of the bit-serial adder. The master issues requests
// and the slave, which is the adder itself, returns results.
interface bit_serial_add_ctrl_if #(
  parameter int unsigned WIDTH = bit_serial_add_ctrl_pkg::BSA_WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] aa;
  logic [WIDTH-1:0] bb;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ss;
  logic             cc;
  logic             ov;

  modport master (
    output start, aa, bb, cin,
    input  busy, done, ss, cc, ov
  );

  modport slave (
    input  start, aa, bb, cin,
    output busy, done, ss, cc, ov
  );

endinterface

// File: rtl/bit_serial_add_ctrl_fa.sv
// Structural one-bit full adder FA_st. It serves as the bit slice of the
// serial adder.
module FA_st (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic axb;
  logic gen;
  logic prp;

  xor u_x1 (axb, a, b);
  xor u_x2 (s, axb, ci);
  and u_a1 (gen, a, b);
  and u_a2 (prp, axb, ci);
  or  u_o1 (co, gen, prp);

endmodule

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial adder controller. It adds two WIDTH-bit operands LSB-first
// through a single full-adder slice, one bit per cycle.
module bit_serial_add_ctrl
  import bit_serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = BSA_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  bit_serial_add_ctrl_if.slave bus
);

  localparam int unsigned    CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  bsa_state_e       state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] s_sr_q;
  logic [WIDTH-1:0] s_sr_d;
  logic [WIDTH-1:0] ss_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;
  logic             busy_q;
  logic             done_q;
  logic             cc_q;
  logic             ov_q;
  logic             slice_s;
  logic             slice_co;

  FA_st u_fa (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .ci (c_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_comb begin
    s_sr_d = {slice_s, s_sr_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      ss_q    <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cc_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            a_sr_q  <= bus.aa;
            b_sr_q  <= bus.bb;
            s_sr_q  <= '0;
            c_q     <= bus.cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          s_sr_q <= s_sr_d;
          c_q    <= slice_co;
          if (cnt_q == CNT_LAST) begin
            // The carry into the MSB is c_q on this edge, so the result is
            // loaded directly and no separate MSB-carry register is kept.
            ss_q    <= s_sr_d;
            cc_q    <= slice_co;
            ov_q    <= c_q ^ slice_co;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ss   = ss_q;
  assign bus.cc   = cc_q;
  assign bus.ov   = ov_q;

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Self-checking bench for bit_serial_add_ctrl. It checks WIDTH=8 and WIDTH=2
// instances against an arithmetic reference model.
module tb_bit_serial_add_ctrl;
  import bit_serial_add_ctrl_pkg::*;

  localparam int unsigned W8 = BSA_WIDTH_DEF;
  localparam int unsigned W2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  bit_serial_add_ctrl_if #(.WIDTH(W8)) if8 ();
  bit_serial_add_ctrl_if #(.WIDTH(W2)) if2 ();

  bit_serial_add_ctrl #(.WIDTH(W8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  bit_serial_add_ctrl #(.WIDTH(W2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  // Signed overflow: the two's-complement sum falls outside the signed range.
  function automatic logic model_ov(int unsigned w, longint a, longint b, longint ci);
    longint half;
    longint sa;
    longint sb;
    longint s;
    half = longint'(1) << (w - 1);
    sa = (a >= half) ? a - 2 * half : a;
    sb = (b >= half) ? b - 2 * half : b;
    s  = sa + sb + ci;
    return (s >= half) || (s < -half);
  endfunction

  // Issues one add on the WIDTH=8 instance and watches samples k=0..W8+1
  // after the accepting edge. The task returns in IDLE, so the next call
  // starts back-to-back with this one.
  task automatic run_add8(input logic [W8-1:0] a, input logic [W8-1:0] b,
                          input logic ci, input int r1, input int r2);
    logic [W8-1:0] prev_s;
    logic          prev_c;
    logic          prev_o;
    logic [W8-1:0] exp_s;
    logic          exp_c;
    logic          exp_o;
    logic [W8-1:0] got_s;
    logic          got_c;
    logic          got_o;
    longint        full;
    int            bc;
    int            dc;
    int            lat;
    prev_s = if8.ss; prev_c = if8.cc; prev_o = if8.ov;
    full  = longint'(a) + longint'(b) + longint'(ci);
    exp_s = W8'(full);
    exp_c = full[W8];
    exp_o = model_ov(W8, longint'(a), longint'(b), longint'(ci));
    bc = 0; dc = 0; lat = -1;
    got_s = '0; got_c = 1'b0; got_o = 1'b0;
    if8.start = 1'b1; if8.aa = a; if8.bb = b; if8.cin = ci;
    @(posedge clk); #1;
    for (int k = 0; k <= int'(W8) + 1; k++) begin
      if8.start = (k == r1) || (k == r2);
      if8.aa  = W8'($urandom);
      if8.bb  = W8'($urandom);
      if8.cin = 1'($urandom);
      if (if8.busy) bc++;
      if (if8.done) begin
        dc++; lat = k;
        got_s = if8.ss; got_c = if8.cc; got_o = if8.ov;
      end
      if (k < int'(W8)) begin
        n_cmp++;
        if ({if8.ss, if8.cc, if8.ov} !== {prev_s, prev_c, prev_o}) begin
          n_bad++;
          $display("FAIL w8_hold k=%0d got ss=%h cc=%b ov=%b exp ss=%h cc=%b ov=%b",
                   k, if8.ss, if8.cc, if8.ov, prev_s, prev_c, prev_o);
        end
      end
      if (k <= int'(W8)) begin
        @(posedge clk); #1;
      end
    end
    n_cmp++;
    if (dc !== 1) begin n_bad++; $display("FAIL w8_done_count got %0d exp 1", dc); end
    n_cmp++;
    if (lat !== int'(W8)) begin n_bad++; $display("FAIL w8_latency got %0d exp %0d", lat, W8); end
    n_cmp++;
    if (bc !== int'(W8) + 1) begin n_bad++; $display("FAIL w8_busy_cycles got %0d exp %0d", bc, W8 + 1); end
    n_cmp++;
    if ({got_c, got_s, got_o} !== {exp_c, exp_s, exp_o}) begin
      n_bad++;
      $display("FAIL w8_result a=%h b=%h ci=%b got ss=%h cc=%b ov=%b exp ss=%h cc=%b ov=%b",
               a, b, ci, got_s, got_c, got_o, exp_s, exp_c, exp_o);
    end
    n_cmp++;
    if ({if8.cc, if8.ss, if8.ov} !== {exp_c, exp_s, exp_o}) begin
      n_bad++;
      $display("FAIL w8_result_hold got ss=%h cc=%b ov=%b exp ss=%h cc=%b ov=%b",
               if8.ss, if8.cc, if8.ov, exp_s, exp_c, exp_o);
    end
  endtask

  task automatic run_add2(input logic [W2-1:0] a, input logic [W2-1:0] b, input logic ci);
    logic [W2-1:0] exp_s;
    logic          exp_c;
    logic          exp_o;
    longint        full;
    int            bc;
    int            dc;
    int            lat;
    full  = longint'(a) + longint'(b) + longint'(ci);
    exp_s = W2'(full);
    exp_c = full[W2];
    exp_o = model_ov(W2, longint'(a), longint'(b), longint'(ci));
    bc = 0; dc = 0; lat = -1;
    if2.start = 1'b1; if2.aa = a; if2.bb = b; if2.cin = ci;
    @(posedge clk); #1;
    if2.start = 1'b0;
    for (int k = 0; k <= int'(W2) + 1; k++) begin
      if2.aa = W2'($urandom); if2.bb = W2'($urandom); if2.cin = 1'($urandom);
      if (if2.busy) bc++;
      if (if2.done) begin
        dc++; lat = k;
        n_cmp++;
        if ({if2.cc, if2.ss, if2.ov} !== {exp_c, exp_s, exp_o}) begin
          n_bad++;
          $display("FAIL w2_result a=%h b=%h ci=%b got ss=%h cc=%b ov=%b exp ss=%h cc=%b ov=%b",
                   a, b, ci, if2.ss, if2.cc, if2.ov, exp_s, exp_c, exp_o);
        end
      end
      if (k <= int'(W2)) begin
        @(posedge clk); #1;
      end
    end
    n_cmp++;
    if (dc !== 1 || lat !== int'(W2)) begin
      n_bad++; $display("FAIL w2_done got count=%0d lat=%0d exp count=1 lat=%0d", dc, lat, W2);
    end
    n_cmp++;
    if (bc !== int'(W2) + 1) begin n_bad++; $display("FAIL w2_busy_cycles got %0d exp %0d", bc, W2 + 1); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({if8.busy, if8.done, if8.ss, if8.cc, if8.ov} !== '0) begin
      n_bad++;
      $display("FAIL reset_w8 got busy=%b done=%b ss=%h cc=%b ov=%b exp all 0",
               if8.busy, if8.done, if8.ss, if8.cc, if8.ov);
    end
    n_cmp++;
    if ({if2.busy, if2.done, if2.ss, if2.cc, if2.ov} !== '0) begin
      n_bad++;
      $display("FAIL reset_w2 got busy=%b done=%b ss=%h cc=%b ov=%b exp all 0",
               if2.busy, if2.done, if2.ss, if2.cc, if2.ov);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_add8(8'hFF, 8'h01, 1'b0, -1, -1);
    run_add8(8'h7F, 8'h01, 1'b0, -1, -1);
    run_add8(8'h80, 8'h80, 1'b1, -1, -1);
  endtask

  task automatic test_ignore_start();
    run_add8(8'h3C, 8'hA5, 1'b1, 3, 8);
    run_add8(8'h12, 8'h34, 1'b0, -1, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) run_add8(W8'($urandom), W8'($urandom), 1'($urandom), -1, -1);
  endtask

  task automatic test_reset_mid_shift();
    int dc;
    dc = 0;
    run_add8(8'hF0, 8'h0F, 1'b1, -1, -1);
    if8.start = 1'b1; if8.aa = 8'h55; if8.bb = 8'h66; if8.cin = 1'b0;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({if8.busy, if8.done, if8.ss, if8.cc, if8.ov} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_shift got busy=%b done=%b ss=%h cc=%b ov=%b exp all 0",
               if8.busy, if8.done, if8.ss, if8.cc, if8.ov);
    end
    for (int k = 0; k < int'(W8) + 2; k++) begin
      if (if8.done || if8.busy) dc++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (dc !== 0) begin n_bad++; $display("FAIL abort_no_done got %0d active cycles exp 0", dc); end
    run_add8(8'hC3, 8'h5A, 1'b1, -1, -1);
  endtask

  task automatic test_random_sweep();
    for (int i = 0; i < 1000; i++) run_add8(W8'($urandom), W8'($urandom), 1'($urandom), -1, -1);
    for (int i = 0; i < 1000; i++) run_add2(W2'($urandom), W2'($urandom), 1'($urandom));
  endtask

  initial begin
    if8.start = 1'b0; if8.aa = '0; if8.bb = '0; if8.cin = 1'b0;
    if2.start = 1'b0; if2.aa = '0; if2.bb = '0; if2.cin = 1'b0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_shift();
    test_random_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
